// File: rtl/pflink_pkg.sv
// pflink_pkg: shared K-codes, framer state and error encodings, and the
// CRC-16-CCITT word update used by the PF-link RX framer.
package pflink_pkg;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_IDLE  = 8'hF7;
  localparam logic [7:0] K_PAD   = 8'h1C;

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    TRAIL
  } state_e;

  typedef enum logic [2:0] {
    OK          = 3'd0,
    CHECK       = 3'd1,
    TRUNC       = 3'd2,
    LINKDOWN    = 3'd3,
    RESTART     = 3'd4,
    TAGMISMATCH = 3'd5
  } err_code_e;

  // One full 32-bit word through the CCITT polynomial, MSB first, unreflected.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [31:0] word);
    logic [15:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/pflink_rx_check.sv
// pflink_rx_check: running payload check accumulator for one frame.
// PFLINK_RX_FRAMER_CRC_EN selects CRC-16-CCITT; otherwise a 16-bit additive sum.
module pflink_rx_check
  import pflink_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        update,
  input  logic [31:0] data,
  output logic [15:0] result
);

  logic [15:0] acc;
  logic [15:0] acc_init;
  logic [15:0] acc_next;

`ifdef PFLINK_RX_FRAMER_CRC_EN
  assign acc_init = 16'hFFFF;
  assign acc_next = crc16_word(acc, data);
`else
  assign acc_init = 16'h0000;
  assign acc_next = acc + data[15:0] + data[31:16];
`endif

  // A frame start restarts the check even if an update arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 16'h0000;
    end else if (clear) begin
      acc <= acc_init;
    end else if (update) begin
      acc <= acc_next;
    end
  end

  assign result = acc;

endmodule

// File: rtl/pflink_rx_framer.sv
// pflink_rx_framer: finds comma-started frames in the PF-link word stream and
// emits checked payload words; PFLINK_RX_FRAMER_CRC_EN selects the CRC check.
module pflink_rx_framer
  import pflink_pkg::*;
#(
  parameter int MAX_LEN = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk_link,
  input  logic             reset_n,
  input  logic [31:0]      rx_d,
  input  logic [3:0]       rx_k,
  input  logic             rx_v,
  input  logic             counter_clear,
  output logic [31:0]      out_d,
  output logic             out_v,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic [2:0]       out_err_code,
  output logic [7:0]       out_tag,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic             busy
);

  localparam logic [16:0] MAX_L = 17'(MAX_LEN);

  state_e      state;
  state_e      state_next;
  logic [7:0]  tag;
  logic [15:0] len;
  logic [15:0] cnt;
  logic [31:0] held_d;
  logic        held_v;
  logic        held_first;
  logic [15:0] check_val;

  logic        is_sof;
  logic        is_pad;
  logic        is_data;
  logic [15:0] sof_len;
  logic        sof_len_ok;

  logic        emit_v;
  logic        emit_eof;
  logic        emit_err;
  err_code_e   emit_code;
  logic        take_sof;
  logic        take_data;
  logic        drop_held;
  logic        ok_inc;
  logic [1:0]  err_inc;
  logic [CNT_W:0] err_sum;

  assign is_sof     = rx_v && (rx_k == 4'b0001) && (rx_d[7:0] == K_COMMA);
  assign is_pad     = rx_v && (rx_k == 4'hF) && (rx_d == {4{K_PAD}});
  assign is_data    = rx_v && (rx_k == 4'h0);
  assign sof_len    = rx_d[31:16];
  assign sof_len_ok = (sof_len != 16'd0) && ({1'b0, sof_len} <= MAX_L);

  pflink_rx_check u_check (
    .clk    (clk_link),
    .rst_n  (reset_n),
    .clear  (take_sof),
    .update (take_data),
    .data   (rx_d),
    .result (check_val)
  );

  // Each payload word is held for one accepted word so the last one can carry EOF.
  always_comb begin
    state_next = state;
    emit_v     = 1'b0;
    emit_eof   = 1'b0;
    emit_err   = 1'b0;
    emit_code  = OK;
    take_sof   = 1'b0;
    take_data  = 1'b0;
    drop_held  = 1'b0;
    ok_inc     = 1'b0;
    err_inc    = 2'd0;
    case (state)
      HUNT: begin
        if (is_sof) begin
          if (sof_len_ok) begin
            take_sof   = 1'b1;
            state_next = DATA;
          end else begin
            err_inc = 2'd1;
          end
        end
      end
      DATA, TRAIL: begin
        if (is_data && state == DATA) begin
          take_data = 1'b1;
          emit_v    = held_v;
          if (cnt + 16'd1 == len) state_next = TRAIL;
        end else if (is_data) begin
          emit_v     = 1'b1;
          emit_eof   = 1'b1;
          drop_held  = 1'b1;
          state_next = HUNT;
          if (rx_d[31:24] != tag) begin
            emit_err  = 1'b1;
            emit_code = TAGMISMATCH;
          end else if (rx_d[15:0] != check_val) begin
            emit_err  = 1'b1;
            emit_code = CHECK;
          end
          ok_inc  = !emit_err;
          err_inc = {1'b0, emit_err};
        end else if (!is_pad) begin
          // Abort; a restarting SOF is length-checked in this same cycle.
          emit_v     = held_v;
          emit_eof   = held_v;
          emit_err   = held_v;
          drop_held  = 1'b1;
          state_next = HUNT;
          if (held_v) emit_code = !rx_v ? LINKDOWN : (is_sof ? RESTART : TRUNC);
          if (is_sof && sof_len_ok) begin
            take_sof   = 1'b1;
            state_next = DATA;
            err_inc    = 2'd1;
          end else if (is_sof) begin
            err_inc = 2'd2;
          end else begin
            err_inc = 2'd1;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk_link or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      tag        <= 8'h00;
      len        <= 16'd0;
      cnt        <= 16'd0;
      held_d     <= 32'h0;
      held_v     <= 1'b0;
      held_first <= 1'b0;
    end else begin
      state <= state_next;
      if (take_sof) begin
        tag <= rx_d[15:8];
        len <= sof_len;
        cnt <= 16'd0;
      end
      if (take_data) begin
        held_d     <= rx_d;
        held_first <= (cnt == 16'd0);
        cnt        <= cnt + 16'd1;
      end
      if (take_data) held_v <= 1'b1;
      else if (drop_held || take_sof) held_v <= 1'b0;
    end
  end

  // Data and tag keep their last value between words; markers are pulses.
  always_ff @(posedge clk_link or negedge reset_n) begin
    if (!reset_n) begin
      out_d        <= 32'h0;
      out_tag      <= 8'h00;
      out_v        <= 1'b0;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
      out_err      <= 1'b0;
      out_err_code <= 3'd0;
    end else begin
      out_v        <= emit_v;
      out_sof      <= emit_v & held_first;
      out_eof      <= emit_eof;
      out_err      <= emit_err;
      out_err_code <= emit_code;
      if (emit_v) begin
        out_d   <= held_d;
        out_tag <= tag;
      end
    end
  end

  // Up to two error events land together when a restart SOF is itself bad.
  assign err_sum = {1'b0, frame_err_cnt} + (CNT_W + 1)'(err_inc);

  always_ff @(posedge clk_link or negedge reset_n) begin
    if (!reset_n) begin
      frame_ok_cnt  <= '0;
      frame_err_cnt <= '0;
    end else if (counter_clear) begin
      frame_ok_cnt  <= '0;
      frame_err_cnt <= '0;
    end else begin
      if (ok_inc && !(&frame_ok_cnt)) frame_ok_cnt <= frame_ok_cnt + 1'b1;
      if (err_sum[CNT_W]) frame_err_cnt <= '1;
      else                frame_err_cnt <= err_sum[CNT_W-1:0];
    end
  end

  assign busy = (state != HUNT);

endmodule

// File: tb/tb_pflink_rx_framer.sv
// tb_pflink_rx_framer: directed and randomized frames against a queue-based
// frame model; a negedge monitor pops expected payload words from a scoreboard.
`timescale 1ns/1ps
module tb_pflink_rx_framer;

  localparam int MAX_LEN = 255;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_link = 1'b0;
  logic             reset_n = 1'b1;
  logic [31:0]      rx_d = '0;
  logic [3:0]       rx_k = '0;
  logic             rx_v = 1'b0;
  logic             counter_clear = 1'b0;
  logic [31:0]      out_d;
  logic             out_v;
  logic             out_sof;
  logic             out_eof;
  logic             out_err;
  logic [2:0]       out_err_code;
  logic [7:0]       out_tag;
  logic [CNT_W-1:0] frame_ok_cnt;
  logic [CNT_W-1:0] frame_err_cnt;
  logic             busy;

  pflink_rx_framer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk_link      (clk_link),
    .reset_n       (reset_n),
    .rx_d          (rx_d),
    .rx_k          (rx_k),
    .rx_v          (rx_v),
    .counter_clear (counter_clear),
    .out_d         (out_d),
    .out_v         (out_v),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .out_err       (out_err),
    .out_err_code  (out_err_code),
    .out_tag       (out_tag),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt),
    .busy          (busy)
  );

  always #5 clk_link = ~clk_link;

  int cyc = 0;
  always @(posedge clk_link) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  tag;
    logic        sof;
    logic        eof;
    logic        err;
    logic [2:0]  code;
  } word_t;

  typedef struct {
    word_t w;
    int    cyc;
  } exp_t;

  typedef logic [31:0] wq_t[$];

  exp_t       sb[$];
  wq_t        pw;
  bit         in_frame = 1'b0;
  int         frame_len = 0;
  logic [7:0] frame_tag = 8'h00;
  int         ok_m = 0;
  int         err_m = 0;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [15:0] ref_check(wq_t q);
`ifdef PFLINK_RX_FRAMER_CRC_EN
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i])
      for (int b = 31; b >= 0; b--)
        c = {c[14:0], 1'b0} ^ (((c[15] ^ q[i][b]) != 1'b0) ? 16'h1021 : 16'h0000);
    return c;
`else
    int unsigned acc;
    acc = 0;
    foreach (q[i]) acc += q[i][15:0] + q[i][31:16];
    return acc[15:0];
`endif
  endfunction

  function automatic void add_ok();
    if (ok_m < CNT_MAX) ok_m++;
  endfunction

  function automatic void add_err();
    if (err_m < CNT_MAX) err_m++;
  endfunction

  function automatic void push_exp(logic [31:0] d, bit first, bit last, logic [2:0] code);
    exp_t e;
    e.w.d    = d;
    e.w.tag  = frame_tag;
    e.w.sof  = first;
    e.w.eof  = last;
    e.w.err  = last && (code != 3'd0);
    e.w.code = last ? code : 3'd0;
    e.cyc    = cyc + 1;
    sb.push_back(e);
  endfunction

  // Frame-level model: a word leaves once its successor in the frame is known.
  function automatic void model_step(logic v, logic [3:0] k, logic [31:0] d, logic clr);
    bit is_sof, is_pad, is_data;
    logic [2:0] code;
    int len;
    is_sof  = v && k == 4'b0001 && d[7:0] == 8'hBC;
    is_pad  = v && k == 4'hF && d == 32'h1C1C1C1C;
    is_data = v && k == 4'h0;
    if (in_frame && !is_pad) begin
      if (is_data && pw.size() < frame_len) begin
        if (pw.size() > 0) push_exp(pw[$], pw.size() == 1, 1'b0, 3'd0);
        pw.push_back(d);
      end else begin
        if (is_data) code = (d[31:24] != frame_tag) ? 3'd5 : ((d[15:0] != ref_check(pw)) ? 3'd1 : 3'd0);
        else         code = !v ? 3'd3 : (is_sof ? 3'd4 : 3'd2);
        if (pw.size() > 0) push_exp(pw[$], pw.size() == 1, 1'b1, code);
        if (code == 3'd0) add_ok(); else add_err();
        in_frame = 1'b0;
      end
    end
    if (is_sof && !in_frame) begin
      len = int'(d[31:16]);
      if (len >= 1 && len <= MAX_LEN) begin
        in_frame  = 1'b1;
        frame_len = len;
        frame_tag = d[15:8];
        pw.delete();
      end else begin
        add_err();
      end
    end
    if (clr) begin
      ok_m  = 0;
      err_m = 0;
    end
  endfunction

  task automatic applyStimulus(input logic v, input logic [3:0] k, input logic [31:0] d,
                               input logic clr = 1'b0);
    rx_v = v;
    rx_k = k;
    rx_d = d;
    counter_clear = clr;
    model_step(v, k, d, clr);
    @(posedge clk_link);
    #1;
  endtask

  task automatic sof(input logic [7:0] t, input logic [15:0] l, input logic clr = 1'b0);
    applyStimulus(1'b1, 4'b0001, {l, t, 8'hBC}, clr);
  endtask

  task automatic dat(input logic [31:0] d);
    applyStimulus(1'b1, 4'h0, d);
  endtask

  task automatic pad();
    applyStimulus(1'b1, 4'hF, 32'h1C1C1C1C);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 4'hF, {4{pflink_pkg::K_IDLE}});
  endtask

  task automatic drop();
    applyStimulus(1'b0, 4'h0, 32'h0);
  endtask

  task automatic checkOutput(input string name);
    checks++;
    if (frame_ok_cnt !== CNT_W'(ok_m)) begin
      errors++;
      $display("[TB] FAIL %s ok_cnt got %0d want %0d", name, frame_ok_cnt, ok_m);
    end
    checks++;
    if (frame_err_cnt !== CNT_W'(err_m)) begin
      errors++;
      $display("[TB] FAIL %s err_cnt got %0d want %0d", name, frame_err_cnt, err_m);
    end
    checks++;
    if (busy !== in_frame) begin
      errors++;
      $display("[TB] FAIL %s busy got %b want %b", name, busy, in_frame);
    end
  endtask

  task automatic checkAllZero(input string name);
    checks++;
    if ({out_d, out_v, out_sof, out_eof, out_err, out_err_code, out_tag,
         frame_ok_cnt, frame_err_cnt, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL %s outputs not zero in reset: out_v=%b out_d=%h ok=%0d err=%0d busy=%b",
               name, out_v, out_d, frame_ok_cnt, frame_err_cnt, busy);
    end
  endtask

  always @(negedge clk_link) begin : monitor
    word_t act;
    exp_t  e;
    if (reset_n) begin
      act = {out_d, out_tag, out_sof, out_eof, out_err, out_err_code};
      if (out_v) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word got d=%h tag=%h at cycle %0d, nothing expected",
                   out_d, out_tag, cyc);
        end else begin
          e = sb.pop_front();
          if (act !== e.w) begin
            errors++;
            $display("[TB] FAIL out_word got d=%h tag=%h sof=%b eof=%b err=%b code=%0d want d=%h tag=%h sof=%b eof=%b err=%b code=%0d",
                     act.d, act.tag, act.sof, act.eof, act.err, act.code,
                     e.w.d, e.w.tag, e.w.sof, e.w.eof, e.w.err, e.w.code);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("[TB] FAIL latency got cycle %0d want cycle %0d", cyc, e.cyc);
          end
        end
      end else begin
        checks++;
        if ({out_sof, out_eof, out_err, out_err_code} !== 6'd0) begin
          errors++;
          $display("[TB] FAIL idle_flags got sof=%b eof=%b err=%b code=%0d want all 0",
                   out_sof, out_eof, out_err, out_err_code);
        end
      end
    end
  end

  task automatic modelReset();
    sb.delete();
    pw.delete();
    in_frame = 1'b0;
    ok_m = 0;
    err_m = 0;
  endtask

  initial begin
    wq_t q;
    #1 reset_n = 1'b0;
    #2 checkAllZero("reset");
    @(posedge clk_link);
    @(posedge clk_link);
    #3 reset_n = 1'b1;
    @(posedge clk_link);
    #1;

    $display("[TB] basic frame");
    sof(8'h5A, 16'd3);
    dat(32'h00010002); dat(32'h00030004); dat(32'h00050006);
    dat(32'h5A000015);
    idle();
    checkOutput("basic");

    $display("[TB] frame with pads");
    sof(8'h5A, 16'd3);
    dat(32'h00010002); pad(); pad(); dat(32'h00030004); dat(32'h00050006);
    pad(); pad(); dat(32'h5A000015);
    idle();
    checkOutput("pads");

    $display("[TB] bad check and bad tag");
    sof(8'h5A, 16'd3);
    dat(32'h00010002); dat(32'h00030004); dat(32'h00050006);
    dat(32'h5A000016);
    sof(8'h5A, 16'd3);
    dat(32'h00010002); dat(32'h00030004); dat(32'h00050006);
    dat(32'h5B000015);
    idle();
    checkOutput("bad_trailer");

    $display("[TB] link drop then L=1 frame");
    sof(8'h33, 16'd4);
    dat(32'hDEAD0001); dat(32'hDEAD0002);
    drop();
    sof(8'h77, 16'd1);
    dat(32'h12345678);
    q.delete(); q.push_back(32'h12345678);
    dat({8'h77, 8'h00, ref_check(q)});
    idle();
    checkOutput("linkdown");

    $display("[TB] restart and length bounds");
    sof(8'h22, 16'd2);
    dat(32'hCAFE0001);
    sof(8'h11, 16'd1);
    dat(32'h00000009);
    q.delete(); q.push_back(32'h00000009);
    dat({8'h11, 8'h00, ref_check(q)});
    sof(8'h01, 16'd0);
    sof(8'h02, 16'(MAX_LEN + 1));
    idle();
    checkOutput("restart");

    $display("[TB] max length frame");
    q.delete();
    sof(8'hA5, 16'(MAX_LEN));
    for (int i = 0; i < MAX_LEN; i++) begin
      q.push_back($urandom);
      dat(q[$]);
    end
    dat({8'hA5, 8'h00, ref_check(q)});
    idle();
    checkOutput("max_len");

    $display("[TB] random frames");
    for (int f = 0; f < 80; f++) begin
      int l, r, ab;
      logic [7:0] t;
      logic [31:0] w;
      if ($urandom_range(0, 3) == 0) idle();
      t = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        sof(t, 16'd0);
        continue;
      end
      l  = $urandom_range(1, 6);
      r  = $urandom_range(0, 9);
      ab = (r == 9) ? $urandom_range(0, l) : l + 1;
      sof(t, 16'(l));
      q.delete();
      for (int i = 0; i < l && i < ab; i++) begin
        if ($urandom_range(0, 3) == 0) pad();
        w = $urandom;
        dat(w);
        q.push_back(w);
      end
      if ($urandom_range(0, 3) == 0) pad();
      case (r)
        7: dat({t, 8'h00, ref_check(q) ^ 16'h0001});
        8: dat({t ^ 8'h01, 8'h00, ref_check(q)});
        9: begin
          case ($urandom_range(0, 2))
            0: drop();
            1: idle();
            default: sof(8'hEE, 16'd1);
          endcase
        end
        default: dat({t, 8'($urandom), ref_check(q)});
      endcase
      if (f % 10 == 9) checkOutput("random");
    end
    idle(); idle();
    checkOutput("random_end");

    $display("[TB] reset mid-frame");
    sof(8'h42, 16'd4);
    dat(32'hAAAA0001); dat(32'hAAAA0002);
    #2 reset_n = 1'b0;
    rx_v = 1'b0;
    modelReset();
    #1 checkAllZero("mid_reset");
    @(posedge clk_link);
    #3 reset_n = 1'b1;
    @(posedge clk_link);
    #1;
    sof(8'h43, 16'd2);
    dat(32'h00100020); dat(32'h00300040);
    q.delete(); q.push_back(32'h00100020); q.push_back(32'h00300040);
    dat({8'h43, 8'h00, ref_check(q)});
    idle();
    checkOutput("after_reset");

    $display("[TB] counter saturation and clear");
    for (int i = 0; i < (1 << CNT_W) + 2; i++) sof(8'h00, 16'd0);
    checkOutput("saturate");
    checks++;
    if (frame_err_cnt !== {CNT_W{1'b1}}) begin
      errors++;
      $display("[TB] FAIL err_saturate got %0d want %0d", frame_err_cnt, CNT_MAX);
    end
    sof(8'h00, 16'd0, 1'b1);
    applyStimulus(1'b1, 4'hF, {4{pflink_pkg::K_IDLE}}, 1'b0);
    checkOutput("clear");

    idle(); idle(); idle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending words want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pflink_rx_framer.md
Name: pflink_rx_framer

Overview:
- Downstream of the PF-link receiver. Consumes its 32-bit aligned word stream {rx_d, rx_k, rx_v} on clk_link.
- Finds comma-started frames, strips PAD words and validates length, tag and check field.
- Emits payload words with SOF/EOF/error markers into the event-buffer FIFO, which has no backpressure.
- Keeps good/bad frame counters for the AXI status registers.

Parameters:
- MAX_LEN, 255: largest legal payload length in words. Must be in 1..65535.
- CNT_W, 16: width of the status counters. Counters saturate.

Ports:
- clk_link  in  1  link word clock
- reset_n  in  1  asynchronous, active-low reset
- rx_d  in  32  received word; byte0 = rx_d[7:0]
- rx_k  in  4  per-byte K flags; rx_k[0] belongs to byte0
- rx_v  in  1  receiver word-valid / link-ok
- counter_clear  in  1  synchronous clear of both counters
- out_d  out  32  payload word
- out_v  out  1  out_d valid this cycle
- out_sof  out  1  first payload word of a frame
- out_eof  out  1  last payload word of a frame (good or aborted)
- out_err  out  1  frame bad; qualified by out_eof
- out_err_code  out  3  error cause; qualified by out_eof
- out_tag  out  8  frame tag; valid with out_v
- frame_ok_cnt  out  CNT_W  good frames
- frame_err_cnt  out  CNT_W  bad frames
- busy  out  1  state != HUNT

Behaviour:
- Word classes, evaluated only when rx_v=1:
  - SOF: rx_k=4'b0001 and rx_d[7:0]=8'hBC. Tag = rx_d[15:8]. Length L = rx_d[31:16].
  - PAD: rx_k=4'hF and all bytes 8'h1C.
  - DATA: rx_k=4'h0.
  - OTHER: anything else, including IDLE 8'hF7.
- Trailer format (a rx_k=0 word): [31:24] = tag echo, [23:16] ignored, [15:0] = check.
- Default check: 16-bit sum mod 2^16 of rx_d[15:0] + rx_d[31:16] over all payload words.
- States:
  - HUNT:
    - SOF with 1 <= L <= MAX_LEN: latch tag and L, cnt=0, clear check, go to DATA.
    - SOF with L=0 or L>MAX_LEN: frame_err_cnt++, stay in HUNT, no output.
    - All other words are ignored.
  - DATA:
    - PAD: skipped; no state change, no cnt change.
    - DATA: accumulate into the check. If a held word exists, emit it (out_v=1, out_sof if it is the first word). Hold the new word. cnt++. When cnt reaches L, go to TRAIL.
  - TRAIL:
    - PAD: skipped.
    - DATA word is the trailer: emit the held word with out_eof=1.
      - Tag mismatch: err code 5.
      - Else check mismatch: err code 1.
      - Else code 0, out_err=0.
    - Return to HUNT. Increment ok or err counter.
- Abort, from DATA or TRAIL:
  - rx_v=0: code 3.
  - OTHER word: code 2.
  - SOF word: code 4.
  - On abort with a held word: emit it with out_eof=1, out_err=1. With no held word: no output. In both cases frame_err_cnt++.
  - Abort on SOF: the new SOF is processed as in HUNT in the same cycle. Its latch/length check happens together with the abort.
- In HUNT, rx_v=0 is ignored.
- Latency: payload word n appears on out_* exactly 1 cycle after the accepted word that follows it (next DATA, trailer, or abort cause).
  - Skipped PADs lengthen the gap but never reorder words.
  - The first word of a frame with L=1 carries both out_sof and out_eof.
- Output rules:
  - out_err, out_err_code and out_eof are 0 whenever out_v=0.
  - out_d and out_tag hold their last values when out_v=0.
- Counters:
  - Saturate at all-ones.
  - counter_clear has priority over an increment in the same cycle.
- Reset (asynchronous, active-low): state=HUNT, held-word flag=0, cnt=0, check=0. All outputs 0, including both counters.
- Reset deasserted mid-frame: no partial frame is ever emitted; the next SOF starts clean.

Optional Feature:
- Macro PFLINK_RX_FRAMER_CRC_EN.
- Defined: the check field is CRC-16-CCITT (poly 16'h1021, init 16'hFFFF, no reflection, no final XOR). Each payload word is processed as 32 bits, MSB first. All 32 steps complete combinationally in the accepting cycle.
- Undefined: the additive 16-bit sum above.
- Ports, latency and error codes are identical in both builds.

Decomposition:
- Package pflink_pkg holds:
  - K_COMMA=8'hBC, K_IDLE=8'hF7, K_PAD=8'h1C.
  - State enum {HUNT, DATA, TRAIL}.
  - Error codes: OK=0, CHECK=1, TRUNC=2, LINKDOWN=3, RESTART=4, TAGMISMATCH=5.
  - The CRC-16 word-update function.
- One sub-module, pflink_rx_check: check accumulator with clear/update inputs and a 16-bit result. The macro selects the CRC or sum implementation inside it.

Test Plan:
- SOF tag=8'h5A, L=3; data 32'h00010002, 32'h00030004, 32'h00050006; trailer 32'h5A00_0015 -> three out_v pulses (sof on the first, eof on the third), out_err=0, frame_ok_cnt=1.
- Same frame with two PAD words inserted between data and before the trailer -> identical output words; eof one cycle after the trailer.
- Same frame with trailer check 16'h0016 -> eof with out_err=1, code 1, frame_err_cnt=1; trailer tag 8'h5B -> code 5.
- SOF L=4, two data words, rx_v=0 -> second word emitted with eof, err, code 3; then a new SOF L=1 frame -> decoded correctly, sof and eof on the same word.
- SOF L=2, one data word, a new SOF (tag 8'h11, L=1) -> first frame aborted with code 4; second frame good; counters ok=1, err=1. SOF with L=0 and SOF with L=MAX_LEN+1 -> no output, err +1 each.
- Assert reset_n low mid-frame and check all outputs are 0 asynchronously; run 2^CNT_W+2 bad frames and check frame_err_cnt saturates at all-ones; pulse counter_clear together with an increment and check the counter reads 0.
